// File: rtl/key_trigger_module.sv
// key_trigger_module: debounced push-button to one-shot SOS start pulse with re-trigger lockout
module key_trigger_module #(
  parameter logic [19:0] T10MS     = 20'd499_999,
  parameter logic [24:0] T500MS    = 25'd24_999_999,
  parameter logic [5:0]  LOCK_HALF = 6'd40
) (
  input  logic CLK,
  input  logic RST,
  input  logic Key_In,
  output logic SOS_En,
  output logic Busy
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;
  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic        key_s;
  logic [19:0] fcnt_q, fcnt_d;
  logic [24:0] tick_q, tick_d;
  logic [5:0]  half_q, half_d;
  logic        busy_q, busy_d, sos_q, sos_d;
  logic        press_evt, tick_wrap, lock_end, accept;
  assign key_s  = sync_q[1];
  assign SOS_En = sos_q;
  assign Busy   = busy_q;
  // two-flop synchronizer; idles at the released level so reset never looks like a press
  always_ff @(posedge CLK or posedge RST)
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], Key_In};
  // debounce state and filter counter registers
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  // debounce next state: a level must stay stable for the whole filter window to be taken
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE:
        if (!key_s) begin
          state_d = PRESS_WAIT;
          fcnt_d  = '0;
        end
      PRESS_WAIT:
        if (key_s)                 state_d = IDLE;
        else if (fcnt_q == T10MS)  state_d = HELD;
        else                       fcnt_d  = fcnt_q + 20'd1;
      HELD:
        if (key_s) begin
          state_d = RELEASE_WAIT;
          fcnt_d  = '0;
        end
      RELEASE_WAIT:
        if (!key_s)                state_d = HELD;
        else if (fcnt_q == T10MS)  state_d = IDLE;
        else                       fcnt_d  = fcnt_q + 20'd1;
      default: state_d = IDLE;
    endcase
  end
  // press event fires only on the PRESS_WAIT->HELD edge, so a long hold yields one event
  always_comb press_evt = (state_q == PRESS_WAIT) && !key_s && (fcnt_q == T10MS);
  // lockout next state: an event on the terminating edge restarts the lockout from zero
  always_comb begin
    tick_wrap = busy_q && (tick_q == T500MS);
    lock_end  = tick_wrap && (half_q == LOCK_HALF - 6'd1);
    accept    = press_evt && (!busy_q || lock_end);
    sos_d     = accept;
    busy_d    = accept ? 1'b1 : busy_q && !lock_end;
    tick_d    = (accept || !busy_q || tick_wrap) ? '0 : tick_q + 25'd1;
    half_d    = (accept || !busy_q || lock_end) ? '0 : half_q + {5'd0, tick_wrap};
  end
  // lockout counters and registered outputs
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      tick_q <= '0;
      half_q <= '0;
      busy_q <= 1'b0;
      sos_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      half_q <= half_d;
      busy_q <= busy_d;
      sos_q  <= sos_d;
    end
endmodule

// File: tb/tb_key_trigger_module.sv
// tb_key_trigger_module: randomized and directed checks of two instances against a run-length reference model
module tb_key_trigger_module;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic Key_In = 1'b1;
  logic sos0, busy0, sos1, busy1;
  int n_chk = 0;
  int n_err = 0;
  int run [2];
  int left [2];
  int pc [2];
  int bc [2];
  bit held [2];
  bit msos [2];
  int need [2] = '{11, 3};
  int lock_len = 8;
  logic d1, d2;

  always #5 CLK = ~CLK;

  key_trigger_module #(.T10MS(20'd9), .T500MS(25'd3), .LOCK_HALF(6'd2)) dut0 (
    .CLK(CLK), .RST(RST), .Key_In(Key_In), .SOS_En(sos0), .Busy(busy0)
  );
  key_trigger_module #(.T10MS(20'd1), .T500MS(25'd3), .LOCK_HALF(6'd2)) dut1 (
    .CLK(CLK), .RST(RST), .Key_In(Key_In), .SOS_En(sos1), .Busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    d1 = 1'b1;
    d2 = 1'b1;
    for (int j = 0; j < 2; j++) begin
      run[j] = 0;
      held[j] = 1'b0;
      left[j] = 0;
      msos[j] = 1'b0;
    end
  endfunction

  // debounced level flips after `need` consecutive samples opposing it; lockout is a remaining-cycle count
  function automatic void model_edge();
    logic ks;
    bit ev, acc;
    ks = d2;
    d2 = d1;
    d1 = Key_In;
    if (RST) begin
      model_reset();
      return;
    end
    for (int j = 0; j < 2; j++) begin
      ev = 1'b0;
      if (held[j] ? ks : !ks) begin
        run[j]++;
        if (run[j] == need[j]) begin
          held[j] = !held[j];
          run[j] = 0;
          ev = held[j];
        end
      end else run[j] = 0;
      acc = ev && left[j] <= 1;
      left[j] = acc ? lock_len : (left[j] > 0 ? left[j] - 1 : 0);
      msos[j] = acc;
    end
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_sos0"}, {31'd0, sos0}, {31'd0, msos[0]});
    chk({tag, "_busy0"}, {31'd0, busy0}, {31'd0, left[0] > 0});
    chk({tag, "_sos1"}, {31'd0, sos1}, {31'd0, msos[1]});
    chk({tag, "_busy1"}, {31'd0, busy1}, {31'd0, left[1] > 0});
  endtask

  task automatic step(input logic k);
    Key_In = k;
    @(posedge CLK);
    model_edge();
    #1;
    check_outs("step");
    pc[0] += int'(sos0);
    pc[1] += int'(sos1);
    bc[0] += int'(busy0);
    bc[1] += int'(busy1);
  endtask

  task automatic clr();
    pc = '{0, 0};
    bc = '{0, 0};
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b1;
    #1;
    model_reset();
    check_outs("rst_async");
    repeat (cycles) step(1'($urandom_range(0, 1)));
    RST = 1'b0;
  endtask

  task automatic hold(input logic k, input int n);
    repeat (n) step(k);
  endtask

  initial begin
    model_reset();
    do_reset(6);
    clr();
    for (int i = 1; i <= 30; i++) begin
      step(1'b0);
      if (i == 12) chk("lat_e12", {31'd0, sos0}, 32'd0);
      if (i == 13) chk("lat_e13", {31'd0, sos0}, 32'd1);
      if (i == 13) chk("busy_e13", {31'd0, busy0}, 32'd1);
    end
    chk("clean_pulses", pc[0], 1);
    chk("clean_busy", bc[0], 8);
    hold(1'b1, 15);

    do_reset(2);
    clr();
    hold(1'b0, 5);
    hold(1'b1, 2);
    hold(1'b0, 5);
    chk("bounce_none", pc[0], 0);
    clr();
    hold(1'b0, 12);
    chk("bounce_one", pc[0], 1);
    hold(1'b1, 15);

    do_reset(2);
    hold(1'b0, 15);
    clr();
    hold(1'b1, 4);
    hold(1'b0, 15);
    chk("glitch_pulses", pc[0], 0);
    hold(1'b1, 15);

    do_reset(2);
    clr();
    hold(1'b0, 3);
    hold(1'b1, 3);
    hold(1'b0, 3);
    hold(1'b1, 20);
    chk("drop_pulses", pc[1], 1);
    chk("drop_busy", bc[1], 8);

    do_reset(2);
    clr();
    hold(1'b0, 3);
    hold(1'b1, 5);
    hold(1'b0, 20);
    chk("retrig_pulses", pc[1], 2);
    chk("retrig_busy", bc[1], 16);
    hold(1'b1, 15);

    do_reset(2);
    hold(1'b0, 15);
    RST = 1'b1;
    #1;
    model_reset();
    check_outs("midrst");
    step(1'b0);
    RST = 1'b0;
    clr();
    hold(1'b0, 12);
    chk("midrst_nopulse", pc[0], 0);
    step(1'b0);
    chk("midrst_repress", pc[0], 1);
    hold(1'b1, 15);

    repeat (60) begin
      logic lvl;
      if ($urandom_range(0, 19) == 0) do_reset(1);
      lvl = 1'($urandom_range(0, 1));
      hold(lvl, int'($urandom_range(1, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/key_trigger_module.md
KEY_TRIGGER_MODULE -- requirements
Module: key_trigger_module

Purpose: debounces a raw push-button and produces the one-cycle start pulse for the downstream SOS LED sequencer. A lockout timer blocks re-triggering while the sequence runs.

Interface
REQ-001 Parameter T10MS, default 20'd499_999: debounce filter terminal count, 10 ms at 50 MHz.
REQ-002 Parameter T500MS, default 25'd24_999_999: lockout tick terminal count, 500 ms at 50 MHz.
REQ-003 Parameter LOCK_HALF, default 6'd40: lockout length in 500 ms ticks (20 s, which covers the 19.5 s SOS sequence).
REQ-004 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 Key_In  input  1  raw, asynchronous button level, active-low (0 = pressed).
REQ-007 SOS_En  output  1  registered start pulse to the sequencer, high for exactly one CLK cycle per accepted press.
REQ-008 Busy  output  1  registered; high while the lockout runs.

Function
REQ-009 Key_In SHALL pass through a two-flop synchronizer (key_s) before any use; the synchronizer flops reset to 1.
REQ-010 The debounce FSM SHALL have four states: IDLE, PRESS_WAIT, HELD and RELEASE_WAIT. It SHALL use one filter counter, fcnt, of 20 bits.
REQ-011 IDLE: key_s=0 -> PRESS_WAIT with fcnt<=0; otherwise hold.
REQ-012 PRESS_WAIT: key_s=1 -> IDLE (bounce rejected); key_s=0 and fcnt==T10MS -> HELD and raise a press event; otherwise fcnt<=fcnt+1.
REQ-013 HELD: key_s=1 -> RELEASE_WAIT with fcnt<=0; otherwise hold. HELD SHALL never generate further events.
REQ-014 RELEASE_WAIT: key_s=0 -> HELD (glitch rejected, no event); key_s=1 and fcnt==T10MS -> IDLE; otherwise fcnt<=fcnt+1.
REQ-015 A press event SHALL be accepted when Busy=0, or when the lockout terminates on the same edge (REQ-019). Otherwise it SHALL be silently dropped.
REQ-016 On an accepted event, SOS_En<=1 and Busy<=1 on the same edge as the PRESS_WAIT->HELD transition. SOS_En SHALL return to 0 on the next edge.
REQ-017 Latency: count the first edge that samples Key_In=0 as edge 1. With Key_In held low throughout and Busy=0, SOS_En SHALL be high after edge T10MS+4.
REQ-018 Lockout counting: while Busy=1, a 25-bit tick counter SHALL count 0..T500MS and wrap. Each wrap SHALL increment a 6-bit half counter.
REQ-019 Lockout end: when the half counter equals LOCK_HALF-1 and the tick counter wraps, Busy<=0 and both counters clear. Busy high time SHALL be exactly LOCK_HALF*(T500MS+1) cycles.
REQ-020 Re-trigger on the terminating edge: an accepted event (REQ-015) on that edge restarts the lockout from zero and keeps Busy=1.
REQ-021 While Busy=0, the tick and half counters SHALL hold at 0.
REQ-022 At most one SOS_En pulse SHALL occur per debounced press, regardless of how long the key is held.

Reset
REQ-023 RST=1 SHALL immediately force: FSM=IDLE, fcnt=0, tick=0, half=0, sync flops=1, SOS_En=0, Busy=0. This applies at any time, including mid-filter and mid-lockout.
REQ-024 After RST falls, a key already held low SHALL be treated as a new press. The full debounce time applies before any pulse.

Verification (T10MS=9, T500MS=3, LOCK_HALF=2, so lockout = 8 cycles)
REQ-025 Reset: RST=1 with Key_In toggling -> SOS_En=0 and Busy=0 throughout.
REQ-026 Clean press: Key_In=0 for 30 cycles -> SOS_En high only after edge 13. Busy is high for exactly 8 cycles starting with the SOS_En cycle.
REQ-027 Bounce: Key_In sequence of 0x5, 1x2, 0x5 cycles -> no pulse. A following stable 0 for 12 cycles -> one pulse.
REQ-028 Release glitch: while HELD, Key_In=1 for 4 cycles then 0 -> FSM returns to HELD with no pulse.
REQ-029 Lockout: a second clean press that completes while Busy=1 -> no pulse. A press completing on the lockout-terminating edge -> pulse, and Busy stays high for a fresh 8 cycles.
REQ-030 Mid-lockout reset: RST pulsed 1 cycle at lockout cycle 3 -> Busy=0 asynchronously, counters cleared, and no pulse until a new debounced press.
